// File: rtl/poke_entry.sv
// poke_entry: operator write-entry front end.
//   The operator keys a 32-bit address and a 32-bit data word one nibble at a time
//   from the board switches, then commits a single write over a req/ack handshake.
// Ports:
//   Clk, Rst          clock (rising edge) and synchronous active-low reset
//   switches[3:0]     nibble to shift in; [8] field select (1 addr, 0 data);
//                     [9] write target (1 memory, 0 register)
//   btnLoad/btnCommit raw active-low pushbuttons (synchronized + debounced here)
//   wrAck             write acknowledge, only looked at while wrReq is high
//   wrReq             write request, held until ack or timeout
//   wrToMem, pokeAddr, pokeData, regToPoke   write attributes latched at commit
//   entryShow         field currently being edited, for the display
//   busy              high whenever a write is in flight (state != IDLE)
//   err               sticky timeout flag, cleared by the next accepted commit

// Button conditioner: 2-flop synchronizer, then a saturating count of consecutive
// low samples. press is a one-cycle pulse on the cycle the count reaches CYCLES;
// saturation keeps it from firing again until the button is released.
module poke_debounce #(
  parameter int CYCLES = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic btn_raw,
  output logic press
);
  localparam int CW = $clog2(CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    if (sync2_q) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != CW'(CYCLES)) cnt_d = cnt_q + CW'(1);
      press = (cnt_q == CW'(CYCLES - 1));
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// state | meaning
// IDLE  | no write in flight; commit events accepted
// REQ   | wrReq high, waiting for wrAck or timeout
// DONE  | one-cycle low gap before the next request can start
module poke_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_TIMEOUT     = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [9:0]  switches,
  input  logic        btnLoad,
  input  logic        btnCommit,
  input  logic        wrAck,
  output logic        wrReq,
  output logic        wrToMem,
  output logic [4:0]  regToPoke,
  output logic [31:0] pokeAddr,
  output logic [31:0] pokeData,
  output logic [31:0] entryShow,
  output logic        busy,
  output logic        err
);
  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_field_q, addr_field_d;
  logic [31:0]   data_field_q, data_field_d;
  logic [31:0]   poke_addr_q, poke_addr_d;
  logic [31:0]   poke_data_q, poke_data_d;
  logic          wr_to_mem_q, wr_to_mem_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          load_ev, commit_ev;
  logic          unused_sw;

  assign unused_sw = ^switches[7:4];

  poke_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .Clk    (Clk),
    .Rst    (Rst),
    .btn_raw(btnLoad),
    .press  (load_ev)
  );

  poke_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_commit (
    .Clk    (Clk),
    .Rst    (Rst),
    .btn_raw(btnCommit),
    .press  (commit_ev)
  );

  always_comb begin
    state_d      = state_q;
    addr_field_d = addr_field_q;
    data_field_d = data_field_q;
    poke_addr_d  = poke_addr_q;
    poke_data_d  = poke_data_q;
    wr_to_mem_d  = wr_to_mem_q;
    err_d        = err_q;
    tmr_d        = tmr_q;

    // Field shift runs in every state. A commit in the same cycle reads the
    // _q values below, so it captures the fields before this shift lands.
    if (load_ev) begin
      if (switches[8]) addr_field_d = {addr_field_q[27:0], switches[3:0]};
      else             data_field_d = {data_field_q[27:0], switches[3:0]};
    end

    case (state_q)
      S_IDLE: begin
        if (commit_ev) begin
          poke_addr_d = addr_field_q;
          poke_data_d = data_field_q;
          wr_to_mem_d = switches[9];
          err_d       = 1'b0;
          tmr_d       = TW'(ACK_TIMEOUT - 1);
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        // Down-counter expires on the ACK_TIMEOUT-th REQ cycle; an ack on
        // that same cycle still wins.
        if (wrAck) begin
          state_d = S_DONE;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q      <= S_IDLE;
      addr_field_q <= '0;
      data_field_q <= '0;
      poke_addr_q  <= '0;
      poke_data_q  <= '0;
      wr_to_mem_q  <= 1'b0;
      err_q        <= 1'b0;
      tmr_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_field_q <= addr_field_d;
      data_field_q <= data_field_d;
      poke_addr_q  <= poke_addr_d;
      poke_data_q  <= poke_data_d;
      wr_to_mem_q  <= wr_to_mem_d;
      err_q        <= err_d;
      tmr_q        <= tmr_d;
    end
  end

  assign wrReq     = (state_q == S_REQ);
  assign busy      = (state_q != S_IDLE);
  assign wrToMem   = wr_to_mem_q;
  assign pokeAddr  = poke_addr_q;
  assign pokeData  = poke_data_q;
  assign regToPoke = poke_addr_q[4:0];
  assign err       = err_q;
  assign entryShow = switches[8] ? addr_field_q : data_field_q;
endmodule

// File: tb/tb_poke_entry.sv
module tb_poke_entry;
  logic        Clk = 1'b0;
  logic        Rst;
  logic [9:0]  switches;
  logic        btnLoad, btnCommit, wrAck;
  logic        wrReq, wrToMem, busy, err;
  logic [4:0]  regToPoke;
  logic [31:0] pokeAddr, pokeData, entryShow;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: the two fields as plain numbers.
  logic [31:0] addr_m = 32'h0;
  logic [31:0] data_m = 32'h0;

  poke_entry dut (
    .Clk(Clk), .Rst(Rst), .switches(switches), .btnLoad(btnLoad),
    .btnCommit(btnCommit), .wrAck(wrAck), .wrReq(wrReq), .wrToMem(wrToMem),
    .regToPoke(regToPoke), .pokeAddr(pokeAddr), .pokeData(pokeData),
    .entryShow(entryShow), .busy(busy), .err(err)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Hold load low for len cycles, then release long enough for the debouncer to re-arm.
  task automatic press_load(input int len);
    btnLoad = 1'b0;
    repeat (len) @(negedge Clk);
    btnLoad = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  task automatic hold_commit(input int len);
    btnCommit = 1'b0;
    repeat (len) @(negedge Clk);
    btnCommit = 1'b1;
  endtask

  task automatic model_shift(input logic sel, input logic [3:0] nib);
    if (sel) addr_m = (addr_m << 4) | {28'h0, nib};
    else     data_m = (data_m << 4) | {28'h0, nib};
  endtask

  task automatic load_nibble(input logic sel, input logic [3:0] nib, input int len);
    logic [31:0] exp;
    switches[8]   = sel;
    switches[3:0] = nib;
    press_load(len);
    if (len >= 4) model_shift(sel, nib);
    exp = sel ? addr_m : data_m;
    tests_run++;
    if (entryShow !== exp) begin
      tests_failed++;
      $display("FAIL load len=%0d sel=%0d: entryShow got %h expected %h", len, sel, entryShow, exp);
    end
  endtask

  // Commit and answer with ack on REQ cycle k (k=0: never ack).
  task automatic do_commit(input int k, input string name);
    logic [31:0] exp_addr, exp_data;
    logic        exp_mem, exp_err;
    int          c, hi, exp_hi;
    bit          done;
    exp_addr = addr_m;
    exp_data = data_m;
    exp_mem  = switches[9];
    exp_hi   = (k == 0 || k > 16) ? 16 : k;
    exp_err  = (k == 0 || k > 16);
    fork hold_commit(6); join_none
    c = 0;
    while (!wrReq && c < 20) begin @(negedge Clk); c++; end
    tests_run++;
    if (!wrReq) begin
      tests_failed++;
      $display("FAIL %s req_start: wrReq got 0 expected 1 within 20 cycles", name);
    end else begin
      tests_run++;
      if (pokeAddr !== exp_addr || pokeData !== exp_data || regToPoke !== exp_addr[4:0] ||
          wrToMem !== exp_mem || err !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s latch: got a=%h d=%h r=%h m=%b e=%b b=%b expected a=%h d=%h r=%h m=%b e=0 b=1",
                 name, pokeAddr, pokeData, regToPoke, wrToMem, err, busy,
                 exp_addr, exp_data, exp_addr[4:0], exp_mem);
      end
      hi = 1;
      done = 0;
      while (!done && hi <= 40) begin
        if (hi == k) wrAck = 1'b1;
        @(negedge Clk);
        wrAck = 1'b0;
        if (!wrReq) done = 1;
        else hi++;
      end
      tests_run++;
      if (hi !== exp_hi) begin
        tests_failed++;
        $display("FAIL %s req_len: wrReq high %0d cycles expected %0d", name, hi, exp_hi);
      end
      tests_run++;
      if (err !== exp_err || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s done: got err=%b busy=%b expected err=%b busy=1", name, err, busy, exp_err);
      end
      @(negedge Clk);
      tests_run++;
      if (busy !== 1'b0 || wrReq !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s idle: got busy=%b wrReq=%b expected 0 0", name, busy, wrReq);
      end
    end
    repeat (6) @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    tests_run++;
    if (wrReq !== 0 || wrToMem !== 0 || regToPoke !== 0 || pokeAddr !== 0 ||
        pokeData !== 0 || entryShow !== 0 || busy !== 0 || err !== 0) begin
      tests_failed++;
      $display("FAIL reset: got req=%b mem=%b reg=%h a=%h d=%h show=%h busy=%b err=%b expected all 0",
               wrReq, wrToMem, regToPoke, pokeAddr, pokeData, entryShow, busy, err);
    end
    Rst = 1'b1;
    addr_m = 0;
    data_m = 0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_debounce();
    load_nibble(1'b0, 4'hA, 3);
    load_nibble(1'b0, 4'hB, 6);
    load_nibble(1'b0, 4'hC, 4);
    load_nibble(1'b1, 4'h5, 2);
    for (int i = 0; i < 10; i++)
      load_nibble(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), int'($urandom_range(1, 8)));
  endtask

  task automatic test_entry();
    for (int i = 1; i <= 8; i++) load_nibble(1'b0, 4'(i), 6);
    tests_run++;
    if (entryShow !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL entry8: entryShow got %h expected 12345678", entryShow);
    end
    load_nibble(1'b0, 4'h9, 6);
    tests_run++;
    if (entryShow !== 32'h23456789) begin
      tests_failed++;
      $display("FAIL entry9: entryShow got %h expected 23456789", entryShow);
    end
  endtask

  task automatic test_reg_write();
    for (int i = 0; i < 8; i++) load_nibble(1'b1, (i >= 6) ? 4'h1 : 4'h0, 6);
    for (int i = 0; i < 8; i++) load_nibble(1'b0, 4'h9, 6);
    switches[9] = 1'b0;
    do_commit(3, "reg_write");
    tests_run++;
    if (regToPoke !== 5'h11 || pokeData !== 32'h99999999 || wrToMem !== 1'b0) begin
      tests_failed++;
      $display("FAIL reg_write_vals: got r=%h d=%h m=%b expected r=11 d=99999999 m=0",
               regToPoke, pokeData, wrToMem);
    end
  endtask

  task automatic test_timeout();
    switches[9] = 1'b1;
    do_commit(0, "timeout");
    switches[9] = 1'b0;
    do_commit(2, "after_timeout");
  endtask

  task automatic test_ignored_commit();
    int c, hi;
    fork hold_commit(6); join_none
    c = 0;
    while (!wrReq && c < 20) begin @(negedge Clk); c++; end
    @(negedge Clk);
    fork hold_commit(6); join_none
    hi = 2;
    c = 0;
    while (wrReq && c < 40) begin @(negedge Clk); c++; if (wrReq) hi++; end
    tests_run++;
    if (hi !== 16 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ignored_commit: wrReq high %0d err=%b expected 16 err=1", hi, err);
    end
    c = 0;
    repeat (12) begin @(negedge Clk); if (wrReq) c++; end
    tests_run++;
    if (c !== 0) begin
      tests_failed++;
      $display("FAIL ignored_commit_norestart: wrReq high %0d cycles expected 0", c);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp;
    int c;
    exp = addr_m;
    switches[8]   = 1'b1;
    switches[3:0] = 4'h7;
    wrAck = 1'b1;
    fork hold_commit(6); join_none
    btnLoad = 1'b0;
    c = 0;
    while (!wrReq && c < 20) begin
      @(negedge Clk);
      c++;
      if (c == 6) btnLoad = 1'b1;
    end
    tests_run++;
    if (pokeAddr !== exp) begin
      tests_failed++;
      $display("FAIL same_cycle_latch: pokeAddr got %h expected %h", pokeAddr, exp);
    end
    btnLoad = 1'b1;
    @(negedge Clk);
    wrAck = 1'b0;
    repeat (8) @(negedge Clk);
    model_shift(1'b1, 4'h7);
    tests_run++;
    if (entryShow !== addr_m) begin
      tests_failed++;
      $display("FAIL same_cycle_shift: entryShow got %h expected %h", entryShow, addr_m);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    fork hold_commit(6); join_none
    c = 0;
    while (!wrReq && c < 20) begin @(negedge Clk); c++; end
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    switches[8] = 1'b1;
    @(negedge Clk);
    tests_run++;
    if (wrReq !== 0 || busy !== 0 || pokeAddr !== 0 || pokeData !== 0 || err !== 0 || entryShow !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid: got req=%b busy=%b a=%h d=%h err=%b show=%h expected all 0",
               wrReq, busy, pokeAddr, pokeData, err, entryShow);
    end
    switches[8] = 1'b0;
    #1;
    tests_run++;
    if (entryShow !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_data: entryShow got %h expected 0", entryShow);
    end
    Rst = 1'b1;
    addr_m = 0;
    data_m = 0;
    c = 0;
    repeat (10) begin @(negedge Clk); if (busy) c++; end
    tests_run++;
    if (c !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_quiet: busy high %0d cycles expected 0", c);
    end
  endtask

  task automatic test_random();
    int k;
    for (int t = 0; t < 6; t++) begin
      repeat ($urandom_range(1, 4)) load_nibble(1'b1, 4'($urandom_range(0, 15)), 6);
      repeat ($urandom_range(1, 4)) load_nibble(1'b0, 4'($urandom_range(0, 15)), 6);
      switches[9] = 1'($urandom_range(0, 1));
      k = int'($urandom_range(0, 15));
      if (k == 15) k = 20;
      do_commit(k, "random");
    end
  endtask

  initial begin
    Rst       = 1'b0;
    switches  = 10'h0;
    btnLoad   = 1'b1;
    btnCommit = 1'b1;
    wrAck     = 1'b0;
    @(negedge Clk);
    test_reset();
    test_debounce();
    test_entry();
    test_reg_write();
    test_timeout();
    test_ignored_commit();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
